// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_pkg : shared types and constants for the MIPS pipeline front end      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mips_pkg;

    localparam int                WORD_W         = 32;
    localparam logic [WORD_W-1:0] PC_INC         = 32'd4;
    localparam logic [WORD_W-1:0] MIPS_RESET_PC  = 32'h0000_0000;
    localparam logic [WORD_W-1:0] MIPS_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        MISS  = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_reg : program counter flop with load / increment / hold select          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = MIPS_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_value,
    input  logic              inc,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4
);

    // Modulo-2^32 add: the top word address wraps to 0 silently.
    assign pc_plus4 = pc + PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage : IF stage - PC, imem request, IF/ID output registers          |
// | Optional FETCH_PERF_CNT_EN adds fetch_cnt / bubble_cnt.  Rev 1.0           |
// +----------------------------------------------------------------------------+
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = MIPS_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_INSTR = MIPS_NOP_INSTR
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_PC,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [WORD_W-1:0] next_PC1,
    output logic [WORD_W-1:0] instruct1,
    output logic              fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_cnt,
    output logic [WORD_W-1:0] bubble_cnt
`endif
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              pc_load;
    logic              pc_inc;
    logic              capture;
    logic              bubble;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] redirect_aligned;

    assign redirect_aligned = redirect_PC & ~32'h0000_0003;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (CLK),
        .rst_n      (RSTn),
        .load       (pc_load),
        .load_value (redirect_aligned),
        .inc        (pc_inc),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        capture   = 1'b0;
        bubble    = 1'b0;
        if (redirect) begin
            state_nxt = FETCH;
            pc_load   = 1'b1;
            bubble    = 1'b1;
        end else if (flush) begin
            bubble    = 1'b1;
        end else if (!stall && state != BOOT) begin
            if (imem_ready) begin
                capture   = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = FETCH;
            end else begin
                bubble    = 1'b1;
                state_nxt = MISS;
            end
        end
        // BOOT lasts exactly one cycle regardless of pipeline controls.
        if (state == BOOT) begin
            state_nxt = FETCH;
        end
    end

    assign imem_req  = (state != BOOT);
    assign imem_addr = pc;

    // next_PC1 is left untouched by bubbles; only fetch_valid qualifies it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            instruct1   <= NOP_INSTR;
            next_PC1    <= RESET_PC;
            fetch_valid <= 1'b0;
        end else if (capture) begin
            instruct1   <= imem_rdata;
            next_PC1    <= pc_plus4;
            fetch_valid <= 1'b1;
        end else if (bubble) begin
            instruct1   <= NOP_INSTR;
            fetch_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (capture) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
